reset_release_seq: RTL

Reset release sequencer that drives the upstream reset inputs of NUM_DOMAINS per-domain reset synchronizers.
- Releases domains strictly in index order (0 first), one at a time.
- Before releasing the next domain, waits for the previous domain's synchronized reset to come back deasserted.
- Supports a software-requested re-reset of all domains and reports completion and ack-timeout errors.
- Sits in the always-on clock domain of the reset controller, upstream of the per-domain synchronizers.

---
 rtl/reset_seq_pkg.sv | 17 +
 rtl/reset_ack_sync.sv | 19 +
 rtl/reset_release_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state encoding, counter widths and index-width helper for the reset release sequencer.
package reset_seq_pkg;

   localparam int DLY_W = 8;
   localparam int TO_W  = 16;

`ifdef RST_SEQ_TIMEOUT_EN
   typedef enum logic [2:0] {WAIT_DLY, RELEASE, WAIT_ACK, DONE, ASSERT, ERR} state_t;
`else
   typedef enum logic [2:0] {WAIT_DLY, RELEASE, WAIT_ACK, DONE, ASSERT} state_t;
`endif

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/reset_ack_sync.sv
// reset_ack_sync: flop-chain synchronizer for one returned domain ack, clears to 0 on reset.
module reset_ack_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync;

   always_ff @(posedge clk or posedge rst)
      if (rst) sync <= '0;
      else     sync <= {sync[STAGES-2:0], d};

   assign q = sync[STAGES-1];

endmodule

// File: rtl/reset_release_seq.sv
// reset_release_seq: releases per-domain upstream resets one at a time in index order, waiting for each synchronized ack.
// Define RST_SEQ_TIMEOUT_EN to enable ack timeout detection (ERR state, timeout_err, err_domain).
module reset_release_seq
   import reset_seq_pkg::*;
#(
   parameter int  NUM_DOMAINS     = 4,
   parameter int  RELEASE_DLY     = 16,
   parameter int  ACK_TIMEOUT     = 255,
   parameter int  ACK_SYNC_STAGES = 2,
   localparam int IDX_W           = idx_w(NUM_DOMAINS)
) (
   input  logic                   sync_clock_in,
   input  logic                   reset_in,
   input  logic                   sw_reset_req,
   input  logic [NUM_DOMAINS-1:0] domain_synced_n_in,
   output logic [NUM_DOMAINS-1:0] domain_reset_n_out,
   output logic                   seq_busy,
   output logic                   seq_done,
   output logic                   timeout_err,
   output logic [IDX_W-1:0]       err_domain
);

   if (NUM_DOMAINS < 1 || NUM_DOMAINS > 16 || RELEASE_DLY < 1 || RELEASE_DLY > 255 ||
       ACK_TIMEOUT < 1 || ACK_TIMEOUT > 65535 || ACK_SYNC_STAGES < 2) begin : g_bad_param
      $error("reset_release_seq: parameter out of range");
   end

   state_t                 state, state_nx;
   logic [IDX_W-1:0]       idx, idx_nx;
   logic [DLY_W-1:0]       dly_cnt, dly_nx;
   logic [NUM_DOMAINS-1:0] rst_n_nx;
   logic [NUM_DOMAINS-1:0] ack;
   logic                   last;

   for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_sync
      reset_ack_sync #(.STAGES(ACK_SYNC_STAGES)) u_sync (
         .clk (sync_clock_in),
         .rst (reset_in),
         .d   (domain_synced_n_in[i]),
         .q   (ack[i])
      );
   end

   assign last = idx == IDX_W'(NUM_DOMAINS - 1);

`ifdef RST_SEQ_TIMEOUT_EN
   logic [TO_W-1:0]  to_cnt, to_nx;
   logic             err_q, err_nx;
   logic [IDX_W-1:0] dom_q, dom_nx, low;
   logic             to_expired;

   assign to_expired  = to_cnt == TO_W'(ACK_TIMEOUT - 1);
   assign timeout_err = err_q;
   assign err_domain  = dom_q;

   always_comb begin
      low = '0;
      for (int i = NUM_DOMAINS - 1; i >= 0; i--)
         if (ack[i]) low = IDX_W'(i);
   end

   always_ff @(posedge sync_clock_in or posedge reset_in)
      if (reset_in) begin
         to_cnt <= '0;
         err_q  <= 1'b0;
         dom_q  <= '0;
      end else begin
         to_cnt <= to_nx;
         err_q  <= err_nx;
         dom_q  <= dom_nx;
      end
`else
   assign timeout_err = 1'b0;
   assign err_domain  = '0;
`endif

   // Domain resets are plain flops so the upstream synchronizers never see a glitch.
   always_ff @(posedge sync_clock_in or posedge reset_in)
      if (reset_in) begin
         state              <= WAIT_DLY;
         idx                <= '0;
         dly_cnt            <= '0;
         domain_reset_n_out <= '0;
      end else begin
         state              <= state_nx;
         idx                <= idx_nx;
         dly_cnt            <= dly_nx;
         domain_reset_n_out <= rst_n_nx;
      end

   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      dly_nx   = dly_cnt;
      rst_n_nx = domain_reset_n_out;
`ifdef RST_SEQ_TIMEOUT_EN
      to_nx    = '0;
      err_nx   = err_q;
      dom_nx   = dom_q;
`endif
      case (state)
         WAIT_DLY: begin
            state_nx = (dly_cnt == DLY_W'(RELEASE_DLY - 1)) ? RELEASE : WAIT_DLY;
            dly_nx   = (dly_cnt == DLY_W'(RELEASE_DLY - 1)) ? '0 : dly_cnt + 1'b1;
         end
         RELEASE: begin
            rst_n_nx[idx] = 1'b1;
            state_nx      = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (ack[idx]) begin
               state_nx = last ? DONE : WAIT_DLY;
               idx_nx   = last ? idx : idx + 1'b1;
            end
`ifdef RST_SEQ_TIMEOUT_EN
            else if (to_expired) begin
               state_nx = ERR;
               err_nx   = 1'b1;
               dom_nx   = idx;
            end else
               to_nx = to_cnt + 1'b1;
`endif
         end
         DONE:
            if (sw_reset_req) begin
               rst_n_nx = '0;
               state_nx = ASSERT;
            end
         ASSERT: begin
            if (ack == '0) begin
               idx_nx   = '0;
               state_nx = WAIT_DLY;
            end
`ifdef RST_SEQ_TIMEOUT_EN
            else if (to_expired) begin
               state_nx = ERR;
               err_nx   = 1'b1;
               dom_nx   = low;
            end else
               to_nx = to_cnt + 1'b1;
`endif
         end
`ifdef RST_SEQ_TIMEOUT_EN
         ERR:
            if (sw_reset_req) begin
               rst_n_nx = '0;
               state_nx = ASSERT;
            end
`endif
         default: state_nx = WAIT_DLY;
      endcase
   end

   assign seq_done = state == DONE;
`ifdef RST_SEQ_TIMEOUT_EN
   assign seq_busy = (state != DONE) && (state != ERR);
`else
   assign seq_busy = state != DONE;
`endif

endmodule
